// File: rtl/tick_period_meter.sv
// Measures the clk-cycle interval between rising edges of a tick strobe and
// keeps last/min/max period, a saturating edge count and a missing-tick flag.
`timescale 1ns/1ps

module tick_period_meter #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] TIMEOUT = 32'd50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [WIDTH-1:0] period_min,
  output logic [WIDTH-1:0] period_max,
  output logic [15:0]      tick_count,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_INIT = '1;

  state_t           state_reg, state_next;
  logic             tick_prev_reg;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] min_reg, min_next;
  logic [WIDTH-1:0] max_reg, max_next;
  logic [15:0]      count_reg, count_next;
  logic             timeout_reg, timeout_next;

  logic             tick_edge;
  logic [15:0]      count_inc;

  // A line held high produces a single edge, so the shortest measurable period is 2.
  assign tick_edge = tick_in & ~tick_prev_reg;
  assign count_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    valid_next   = 1'b0;
    min_next     = min_reg;
    max_next     = max_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;

    if (clear) begin
      state_next   = S_IDLE;
      cnt_next     = '0;
      period_next  = '0;
      min_next     = MIN_INIT;
      max_next     = '0;
      count_next   = '0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (tick_edge) begin
            cnt_next   = CNT_ONE;
            count_next = count_inc;
            state_next = S_MEASURE;
          end
        end
        S_MEASURE: begin
          // An edge landing exactly on cnt==TIMEOUT is still a valid period.
          if (tick_edge) begin
            period_next = cnt_reg;
            valid_next  = 1'b1;
            min_next    = (cnt_reg < min_reg) ? cnt_reg : min_reg;
            max_next    = (cnt_reg > max_reg) ? cnt_reg : max_reg;
            cnt_next    = CNT_ONE;
            count_next  = count_inc;
          end else if (cnt_reg == TIMEOUT) begin
            state_next   = S_TIMEOUT;
            timeout_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        S_TIMEOUT: begin
          // The interval spanning a timeout is meaningless: restart without reporting.
          if (tick_edge) begin
            timeout_next = 1'b0;
            cnt_next     = CNT_ONE;
            count_next   = count_inc;
            state_next   = S_MEASURE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      tick_prev_reg <= 1'b0;
      cnt_reg       <= '0;
      period_reg    <= '0;
      valid_reg     <= 1'b0;
      min_reg       <= MIN_INIT;
      max_reg       <= '0;
      count_reg     <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_prev_reg <= tick_in;
      cnt_reg       <= cnt_next;
      period_reg    <= period_next;
      valid_reg     <= valid_next;
      min_reg       <= min_next;
      max_reg       <= max_next;
      count_reg     <= count_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign period_min   = min_reg;
  assign period_max   = max_reg;
  assign tick_count   = count_reg;
  assign timeout      = timeout_reg;

endmodule
